apb_rr_arbiter: RTL and testbench

// - Round-robin arbiter sharing one APB master port between MASTER_PORTS core-side APB masters.
// - Sits between the cores' APB master ports and the address-decoding interconnect.
// - Holds the grant for one complete SETUP+ACCESS transfer and enforces a legal SETUP phase downstream.
// - Bounds stalled transfers with a per-transfer timeout that returns PSLVERR.

---
 rtl/apb_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one downstream APB port among several core-side APB masters.
// A grant is held for one full SETUP+ACCESS transfer. A stalled ACCESS phase is bounded by a timeout that returns PSLVERR.
module apb_rr_arbiter #(
    parameter int BUS_WIDTH    = 16,
    parameter int MASTER_PORTS = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
    input  logic [MASTER_PORTS-1:0]           S_PWRITE,
    input  logic [MASTER_PORTS-1:0]           S_PSELx,
    input  logic [MASTER_PORTS-1:0]           S_PENABLE,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]           S_PREADY,
    output logic [MASTER_PORTS-1:0]           S_PSLVERR,
    output logic [BUS_WIDTH-1:0]              M_PADDR,
    output logic                              M_PWRITE,
    output logic                              M_PSEL,
    output logic                              M_PENABLE,
    output logic [BUS_WIDTH-1:0]              M_PWDATA,
    input  logic [BUS_WIDTH-1:0]              M_PRDATA,
    input  logic                              M_PREADY,
    output logic                              grant_valid,
    output logic [$clog2(MASTER_PORTS)-1:0]   grant_idx
);

    localparam int IDX_W   = $clog2(MASTER_PORTS);
    localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};
    localparam logic [TIMER_W-1:0] TIMER_LAST = (TIMEOUT > 0) ? TIMER_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0]   LAST_INIT  = IDX_W'(MASTER_PORTS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]     next_grant;
    logic                 found;
    int                   cand;
    logic                 sel_g;
    logic                 complete;
    logic                 timeout_err;

    assign sel_g = S_PSELx[grant_q];

    // Scan forward from the master after the last one served, so the most recent winner has lowest priority
    always_comb begin
        next_grant = '0;
        found      = 1'b0;
        cand       = 0;
        for (int k = 1; k <= MASTER_PORTS; k++) begin
            cand = (int'(last_q) + k) % MASTER_PORTS;
            if (!found && S_PSELx[cand]) begin
                found      = 1'b1;
                next_grant = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        timer_d     = timer_q;
        complete    = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (|S_PSELx) begin
                    grant_d = next_grant;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!sel_g) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    timer_d = '0;
                end
            end
            ACCESS: begin
                if (!sel_g) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end else if (M_PREADY) begin
                    complete = 1'b1;
                    last_d   = grant_q;
                    state_d  = IDLE;
                end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
                    timeout_err = 1'b1;
                    last_d      = grant_q;
                    state_d     = IDLE;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Downstream bus follows the granted master combinationally; PENABLE is forced low in SETUP
    always_comb begin
        M_PADDR   = '0;
        M_PWRITE  = 1'b0;
        M_PSEL    = 1'b0;
        M_PENABLE = 1'b0;
        M_PWDATA  = '0;
        S_PRDATA  = '0;
        S_PREADY  = '0;
        S_PSLVERR = '0;
        if (state_q != IDLE) begin
            M_PADDR   = S_PADDR[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH];
            M_PWDATA  = S_PWDATA[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH];
            M_PWRITE  = S_PWRITE[grant_q];
            M_PSEL    = sel_g;
            M_PENABLE = (state_q == ACCESS);
        end
        if (complete) begin
            S_PREADY[grant_q] = 1'b1;
            S_PRDATA[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH] = M_PRDATA;
        end else if (timeout_err) begin
            S_PREADY[grant_q]  = 1'b1;
            S_PSLVERR[grant_q] = 1'b1;
        end
    end

    assign grant_valid = (state_q != IDLE);
    assign grant_idx   = grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_INIT;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed, table-driven bench for apb_rr_arbiter (4 masters, 16-bit bus, TIMEOUT=4).
// Each vector holds one cycle of inputs and the outputs expected at the following negedge.
module tb_apb_rr_arbiter;

    logic        clk;
    logic        reset;
    logic [63:0] S_PADDR;
    logic [3:0]  S_PWRITE;
    logic [3:0]  S_PSELx;
    logic [3:0]  S_PENABLE;
    logic [63:0] S_PWDATA;
    logic [63:0] S_PRDATA;
    logic [3:0]  S_PREADY;
    logic [3:0]  S_PSLVERR;
    logic [15:0] M_PADDR;
    logic        M_PWRITE;
    logic        M_PSEL;
    logic        M_PENABLE;
    logic [15:0] M_PWDATA;
    logic [15:0] M_PRDATA;
    logic        M_PREADY;
    logic        grant_valid;
    logic [1:0]  grant_idx;

    int compareCount = 0;
    int failCount    = 0;

    logic [15:0] addrTab  [4];
    logic [15:0] wdataTab [4];
    logic [3:0]  writeTab;

    typedef struct {
        logic        rst;
        logic [3:0]  psel;
        logic [3:0]  pen;
        logic        mready;
        logic [15:0] mrdata;
        logic        gv;
        logic [1:0]  gi;
        logic        msel;
        logic        men;
        logic [3:0]  sready;
        logic [3:0]  serr;
        logic [63:0] srdata;
    } vec_t;

    vec_t vecs[$];

    apb_rr_arbiter #(
        .BUS_WIDTH   (16),
        .MASTER_PORTS(4),
        .TIMEOUT     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .S_PADDR    (S_PADDR),
        .S_PWRITE   (S_PWRITE),
        .S_PSELx    (S_PSELx),
        .S_PENABLE  (S_PENABLE),
        .S_PWDATA   (S_PWDATA),
        .S_PRDATA   (S_PRDATA),
        .S_PREADY   (S_PREADY),
        .S_PSLVERR  (S_PSLVERR),
        .M_PADDR    (M_PADDR),
        .M_PWRITE   (M_PWRITE),
        .M_PSEL     (M_PSEL),
        .M_PENABLE  (M_PENABLE),
        .M_PWDATA   (M_PWDATA),
        .M_PRDATA   (M_PRDATA),
        .M_PREADY   (M_PREADY),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] slot(input int idx, input logic [15:0] d);
        return 64'(d) << (idx * 16);
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] psel, input logic [3:0] pen,
                                input logic mready, input logic [15:0] mrdata,
                                input logic gv, input logic [1:0] gi, input logic msel, input logic men,
                                input logic [3:0] sready, input logic [3:0] serr, input logic [63:0] srdata);
        vec_t v;
        v.rst = rst; v.psel = psel; v.pen = pen; v.mready = mready; v.mrdata = mrdata;
        v.gv = gv; v.gi = gi; v.msel = msel; v.men = men;
        v.sready = sready; v.serr = serr; v.srdata = srdata;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        S_PSELx   = v.psel;
        S_PENABLE = v.pen;
        M_PREADY  = v.mready;
        M_PRDATA  = v.mrdata;
    endtask

    // The downstream address/control follow the granted master whenever a grant is active
    task automatic checkOutput(input vec_t v, input string tag);
        logic [15:0] expAddr;
        logic [15:0] expWdata;
        logic        expWrite;
        expAddr  = v.gv ? addrTab[v.gi]  : 16'h0;
        expWdata = v.gv ? wdataTab[v.gi] : 16'h0;
        expWrite = v.gv ? writeTab[v.gi] : 1'b0;
        cmp({tag, ".grant_valid"}, 64'(grant_valid), 64'(v.gv));
        cmp({tag, ".grant_idx"},   64'(grant_idx),   64'(v.gi));
        cmp({tag, ".M_PSEL"},      64'(M_PSEL),      64'(v.msel));
        cmp({tag, ".M_PENABLE"},   64'(M_PENABLE),   64'(v.men));
        cmp({tag, ".M_PADDR"},     64'(M_PADDR),     64'(expAddr));
        cmp({tag, ".M_PWRITE"},    64'(M_PWRITE),    64'(expWrite));
        cmp({tag, ".M_PWDATA"},    64'(M_PWDATA),    64'(expWdata));
        cmp({tag, ".S_PREADY"},    64'(S_PREADY),    64'(v.sready));
        cmp({tag, ".S_PSLVERR"},   64'(S_PSLVERR),   64'(v.serr));
        cmp({tag, ".S_PRDATA"},    S_PRDATA,         v.srdata);
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accessCycles;
        logic seenReady;
        int seq [6];

        addrTab  = '{16'h0100, 16'h0080, 16'h0200, 16'h0300};
        wdataTab = '{16'h1111, 16'hBEEF, 16'h2222, 16'h3333};
        writeTab = 4'b0010;
        S_PADDR  = {addrTab[3], addrTab[2], addrTab[1], addrTab[0]};
        S_PWDATA = {wdataTab[3], wdataTab[2], wdataTab[1], wdataTab[0]};
        S_PWRITE = writeTab;

        // Single write from master 1 straight out of reset
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 0, 16'h0000, 1, 1, 1, 0, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 16'hAAAA, 1, 1, 1, 1, 4'b0010, 4'b0000, slot(1, 16'hAAAA)));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 64'h0));
        // Reset, then masters 0 and 2 collide: 0 wins first
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 16'h0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 0, 16'h0000, 1, 0, 1, 0, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b0101, 4'b0001, 1, 16'h1234, 1, 0, 1, 1, 4'b0001, 4'b0000, slot(0, 16'h1234)));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 0, 16'h0000, 1, 2, 1, 0, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 16'h5678, 1, 2, 1, 1, 4'b0100, 4'b0000, slot(2, 16'h5678)));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2, 0, 0, 4'b0000, 4'b0000, 64'h0));
        // Reset, then all four request continuously with an always-ready slave
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2, 0, 0, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 16'h00C0, 0, 0, 0, 0, 4'b0000, 4'b0000, 64'h0));
        seq = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 6; k++) begin
            vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 16'h00C0, 1, 2'(seq[k]), 1, 0, 4'b0000, 4'b0000, 64'h0));
            vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 16'h00C0, 1, 2'(seq[k]), 1, 1,
                              4'(1 << seq[k]), 4'b0000, slot(seq[k], 16'h00C0)));
            if (k < 5)
                vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 16'h00C0, 0, 2'(seq[k]), 0, 0, 4'b0000, 4'b0000, 64'h0));
            else
                vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2'(seq[k]), 0, 0, 4'b0000, 4'b0000, 64'h0));
        end
        // Master 3: slave answers on the 4th ACCESS cycle, so no timeout error
        vecs.push_back(mk(0, 4'b1000, 4'b1000, 0, 16'h0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b1000, 4'b1000, 0, 16'h0000, 1, 3, 1, 0, 4'b0000, 4'b0000, 64'h0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 4'b1000, 4'b1000, 0, 16'h0000, 1, 3, 1, 1, 4'b0000, 4'b0000, 64'h0));
        vecs.push_back(mk(0, 4'b1000, 4'b1000, 1, 16'h4321, 1, 3, 1, 1, 4'b1000, 4'b0000, slot(3, 16'h4321)));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 0, 3, 0, 0, 4'b0000, 4'b0000, 64'h0));

        applyStimulus(mk(1, 4'b0000, 4'b0000, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 64'h0));
        @(posedge clk);
        @(posedge clk);
        #1;

        foreach (vecs[i]) runVec(vecs[i], $sformatf("v%0d", i));

        // Master 2 with a slave that never answers: the error arrives on the 4th ACCESS cycle
        runVec(mk(0, 4'b0100, 4'b0100, 0, 16'h0000, 0, 3, 0, 0, 4'b0000, 4'b0000, 64'h0), "to.idle");
        runVec(mk(0, 4'b0100, 4'b0100, 0, 16'hFFFF, 1, 2, 1, 0, 4'b0000, 4'b0000, 64'h0), "to.setup");
        applyStimulus(mk(0, 4'b0100, 4'b0100, 0, 16'hFFFF, 0, 0, 0, 0, 4'b0000, 4'b0000, 64'h0));
        accessCycles = 0;
        seenReady    = 1'b0;
        for (int i = 0; i < 10 && !seenReady; i++) begin
            @(negedge clk);
            if (M_PENABLE) accessCycles++;
            if (S_PREADY != 4'b0000) seenReady = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        cmp("to.access_cycles", 64'(accessCycles), 64'd4);
        cmp("to.S_PREADY",      64'(S_PREADY),     64'(4'b0100));
        cmp("to.S_PSLVERR",     64'(S_PSLVERR),    64'(4'b0100));
        cmp("to.S_PRDATA",      S_PRDATA,          64'h0);
        @(posedge clk);
        #1;
        runVec(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2, 0, 0, 4'b0000, 4'b0000, 64'h0), "to.after");

        // Master 1 completes (last=1), then reset hits master 2's ACCESS; afterwards master 0 must win over 2
        runVec(mk(0, 4'b0010, 4'b0010, 0, 16'h0000, 0, 2, 0, 0, 4'b0000, 4'b0000, 64'h0), "rs.idle1");
        runVec(mk(0, 4'b0010, 4'b0010, 0, 16'h0000, 1, 1, 1, 0, 4'b0000, 4'b0000, 64'h0), "rs.setup1");
        runVec(mk(0, 4'b0010, 4'b0010, 1, 16'h0BAD, 1, 1, 1, 1, 4'b0010, 4'b0000, slot(1, 16'h0BAD)), "rs.access1");
        runVec(mk(0, 4'b0100, 4'b0100, 0, 16'h0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 64'h0), "rs.idle2");
        runVec(mk(0, 4'b0100, 4'b0100, 0, 16'h0000, 1, 2, 1, 0, 4'b0000, 4'b0000, 64'h0), "rs.setup2");
        runVec(mk(1, 4'b0100, 4'b0100, 0, 16'h0000, 1, 2, 1, 1, 4'b0000, 4'b0000, 64'h0), "rs.access2");
        runVec(mk(0, 4'b0101, 4'b0101, 1, 16'h7777, 0, 0, 0, 0, 4'b0000, 4'b0000, 64'h0), "rs.after");
        runVec(mk(0, 4'b0101, 4'b0101, 0, 16'h0000, 1, 0, 1, 0, 4'b0000, 4'b0000, 64'h0), "rs.setup0");
        runVec(mk(0, 4'b0101, 4'b0101, 1, 16'h2468, 1, 0, 1, 1, 4'b0001, 4'b0000, slot(0, 16'h2468)), "rs.access0");
        runVec(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 64'h0), "rs.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
